// File: rtl/mc_apb_cfg_shadow.sv
// APB configuration block for the memory controller: staging/active timing registers with a commit handshake.
// Optional sticky LOCK bit (CMD bit1, STATUS bit2) is built in when MC_APB_CFG_LOCK_EN is defined.
module mc_apb_cfg_shadow #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int TW         = 8,
  parameter int RFW        = 25,
  parameter int WAIT_CYC   = 0
) (
  input  logic                  apb_pclk,
  input  logic                  apb_prst_n,
  input  logic                  apb_psel,
  input  logic                  apb_penable,
  input  logic                  apb_pwrite,
  input  logic [ADDR_WIDTH-1:0] apb_paddr,
  input  logic [DATA_WIDTH-1:0] apb_pwdata,
  output logic                  apb_pready,
  output logic [DATA_WIDTH-1:0] apb_prdata,
  output logic                  apb_pslverr,
  input  logic                  mc_busy,
  output logic                  cfg_upd_req,
  input  logic                  cfg_upd_ack,
  output logic                  mc_en,
  output logic [1:0]            axi2array_rw_prio,
  output logic [TW-1:0]         array_tRAS,
  output logic [TW-1:0]         array_tRP,
  output logic [TW-1:0]         array_tRC,
  output logic [TW-1:0]         array_tRCD_WR,
  output logic [TW-1:0]         array_tRCD_RD,
  output logic [TW-1:0]         array_tWR,
  output logic [TW-1:0]         array_tRTP,
  output logic [RFW-1:0]        array_rf_period_0,
  output logic [RFW-1:0]        array_rf_period_1,
  output logic                  array_rf_period_sel
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
  state_t state, state_nxt;
  logic [3:0] wait_cnt;

  logic [1:0]     stg_prio;
  logic [TW-1:0]  stg_tras, stg_trp, stg_trc, stg_trcd_wr, stg_trcd_rd, stg_twr, stg_trtp;
  logic [RFW-1:0] stg_rf0, stg_rf1;
  logic           stg_rf_sel;
  logic           pending, lock, commit_now, do_copy;
  logic [3:0]     idx;
  logic           unmapped, is_staged, is_cmd, is_status, err, wr_en;
  logic [DATA_WIDTH-1:0] rd_data;

  always_ff @(posedge apb_pclk or negedge apb_prst_n) begin
    if (!apb_prst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)
        wait_cnt <= 4'(WAIT_CYC);
      else if (state == ACCESS && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Zero wait states skip ACCESS so PREADY rises in the first access cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (apb_psel && !apb_penable) state_nxt = (WAIT_CYC == 0) ? DONE : ACCESS;
      ACCESS:  if (wait_cnt <= 4'd1) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    apb_pready  = (state == DONE);
    apb_pslverr = (state == DONE) && err;
    apb_prdata  = ((state == DONE) && !apb_pwrite && !err) ? rd_data : '0;
  end

  assign idx        = apb_paddr[5:2];
  assign unmapped   = apb_paddr > ADDR_WIDTH'(35);
  assign is_staged  = (idx >= 4'd1) && (idx <= 4'd6);
  assign is_cmd     = (idx == 4'd7);
  assign is_status  = (idx == 4'd8);
  assign err        = unmapped
                    || (apb_pwrite && is_status)
                    || (apb_pwrite && pending && (is_staged || is_cmd))
                    || (apb_pwrite && lock && (is_staged || (is_cmd && apb_pwdata[0])));
  assign wr_en      = apb_psel && apb_penable && apb_pready && apb_pwrite && !err;
  assign commit_now = wr_en && is_cmd && apb_pwdata[0];
  // An idle controller (mc_en=0) takes the copy at once, including a drop of mc_en mid-request.
  assign do_copy    = (commit_now && !mc_en) || (pending && (cfg_upd_ack || !mc_en));
  assign cfg_upd_req = pending;

  always_ff @(posedge apb_pclk or negedge apb_prst_n) begin
    if (!apb_prst_n) begin
      mc_en <= 1'b0; stg_prio <= '0; stg_rf_sel <= 1'b0;
      stg_tras <= '0; stg_trp <= '0; stg_trc <= '0;
      stg_trcd_wr <= '0; stg_trcd_rd <= '0; stg_twr <= '0; stg_trtp <= '0;
      stg_rf0 <= '0; stg_rf1 <= '0;
      pending <= 1'b0;
    end else begin
      if (wr_en) begin
        case (idx)
          4'd0: mc_en <= apb_pwdata[0];
          4'd1: stg_prio <= apb_pwdata[1:0];
          4'd2: begin
            stg_tras <= apb_pwdata[0 +: TW];
            stg_trp  <= apb_pwdata[8 +: TW];
            stg_trc  <= apb_pwdata[16 +: TW];
          end
          4'd3: begin
            stg_trcd_wr <= apb_pwdata[0 +: TW];
            stg_trcd_rd <= apb_pwdata[8 +: TW];
            stg_twr     <= apb_pwdata[16 +: TW];
            stg_trtp    <= apb_pwdata[24 +: TW];
          end
          4'd4: stg_rf0 <= apb_pwdata[RFW-1:0];
          4'd5: stg_rf1 <= apb_pwdata[RFW-1:0];
          4'd6: stg_rf_sel <= apb_pwdata[0];
          default: ;
        endcase
      end
      if (commit_now && mc_en)
        pending <= 1'b1;
      else if (pending && (cfg_upd_ack || !mc_en))
        pending <= 1'b0;
    end
  end

  always_ff @(posedge apb_pclk or negedge apb_prst_n) begin
    if (!apb_prst_n) begin
      axi2array_rw_prio <= '0; array_rf_period_sel <= 1'b0;
      array_tRAS <= '0; array_tRP <= '0; array_tRC <= '0;
      array_tRCD_WR <= '0; array_tRCD_RD <= '0; array_tWR <= '0; array_tRTP <= '0;
      array_rf_period_0 <= '0; array_rf_period_1 <= '0;
    end else if (do_copy) begin
      axi2array_rw_prio <= stg_prio; array_rf_period_sel <= stg_rf_sel;
      array_tRAS <= stg_tras; array_tRP <= stg_trp; array_tRC <= stg_trc;
      array_tRCD_WR <= stg_trcd_wr; array_tRCD_RD <= stg_trcd_rd;
      array_tWR <= stg_twr; array_tRTP <= stg_trtp;
      array_rf_period_0 <= stg_rf0; array_rf_period_1 <= stg_rf1;
    end
  end

`ifdef MC_APB_CFG_LOCK_EN
  always_ff @(posedge apb_pclk or negedge apb_prst_n) begin
    if (!apb_prst_n)
      lock <= 1'b0;
    else if (wr_en && is_cmd && apb_pwdata[1])
      lock <= 1'b1;
  end
`else
  assign lock = 1'b0;
`endif

  always_comb begin
    rd_data = '0;
    case (idx)
      4'd0: rd_data[0] = mc_en;
      4'd1: rd_data[1:0] = stg_prio;
      4'd2: begin
        rd_data[0 +: TW]  = stg_tras;
        rd_data[8 +: TW]  = stg_trp;
        rd_data[16 +: TW] = stg_trc;
      end
      4'd3: begin
        rd_data[0 +: TW]  = stg_trcd_wr;
        rd_data[8 +: TW]  = stg_trcd_rd;
        rd_data[16 +: TW] = stg_twr;
        rd_data[24 +: TW] = stg_trtp;
      end
      4'd4: rd_data[RFW-1:0] = stg_rf0;
      4'd5: rd_data[RFW-1:0] = stg_rf1;
      4'd6: rd_data[0] = stg_rf_sel;
      4'd8: rd_data[2:0] = {lock, mc_busy, pending};
      default: rd_data = '0;
    endcase
  end

endmodule

// File: tb/tb_mc_apb_cfg_shadow.sv
// Directed bench for mc_apb_cfg_shadow: a zero-wait instance for most scenarios and a
// WAIT_CYC=3 instance for wait-state timing.
module tb_mc_apb_cfg_shadow;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic psel = 1'b0, psel_ws = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = '0;
  logic [31:0] pwdata = '0;
  logic mc_busy = 1'b0, ack = 1'b0, ack_ws = 1'b0;

  logic pready, pslverr, req, mc_en, rf_sel;
  logic [31:0] prdata;
  logic [1:0] prio;
  logic [7:0] t_ras, t_rp, t_rc, t_rcd_wr, t_rcd_rd, t_wr, t_rtp;
  logic [24:0] rf0, rf1;

  logic ws_pready, ws_pslverr, ws_req, ws_mc_en, ws_rf_sel;
  logic [31:0] ws_prdata;
  logic [1:0] ws_prio;
  logic [7:0] ws_t_ras, ws_t_rp, ws_t_rc, ws_t_rcd_wr, ws_t_rcd_rd, ws_t_wr, ws_t_rtp;
  logic [24:0] ws_rf0, ws_rf1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mc_apb_cfg_shadow #(.TW(8), .RFW(25), .WAIT_CYC(0)) dut (
    .apb_pclk(clk), .apb_prst_n(rst_n), .apb_psel(psel), .apb_penable(penable),
    .apb_pwrite(pwrite), .apb_paddr(paddr), .apb_pwdata(pwdata),
    .apb_pready(pready), .apb_prdata(prdata), .apb_pslverr(pslverr),
    .mc_busy(mc_busy), .cfg_upd_req(req), .cfg_upd_ack(ack), .mc_en(mc_en),
    .axi2array_rw_prio(prio), .array_tRAS(t_ras), .array_tRP(t_rp), .array_tRC(t_rc),
    .array_tRCD_WR(t_rcd_wr), .array_tRCD_RD(t_rcd_rd), .array_tWR(t_wr), .array_tRTP(t_rtp),
    .array_rf_period_0(rf0), .array_rf_period_1(rf1), .array_rf_period_sel(rf_sel)
  );

  mc_apb_cfg_shadow #(.TW(8), .RFW(25), .WAIT_CYC(3)) dut_ws (
    .apb_pclk(clk), .apb_prst_n(rst_n), .apb_psel(psel_ws), .apb_penable(penable),
    .apb_pwrite(pwrite), .apb_paddr(paddr), .apb_pwdata(pwdata),
    .apb_pready(ws_pready), .apb_prdata(ws_prdata), .apb_pslverr(ws_pslverr),
    .mc_busy(mc_busy), .cfg_upd_req(ws_req), .cfg_upd_ack(ack_ws), .mc_en(ws_mc_en),
    .axi2array_rw_prio(ws_prio), .array_tRAS(ws_t_ras), .array_tRP(ws_t_rp), .array_tRC(ws_t_rc),
    .array_tRCD_WR(ws_t_rcd_wr), .array_tRCD_RD(ws_t_rcd_rd), .array_tWR(ws_t_wr), .array_tRTP(ws_t_rtp),
    .array_rf_period_0(ws_rf0), .array_rf_period_1(ws_rf1), .array_rf_period_sel(ws_rf_sel)
  );

  task automatic apb(input bit ws, input bit wr, input logic [7:0] addr, input logic [31:0] data,
                     output logic [31:0] rd, output logic er, output int nwait);
    int guard;
    @(posedge clk); #1;
    if (ws) psel_ws = 1'b1; else psel = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = addr; pwdata = data;
    @(posedge clk); #1;
    penable = 1'b1;
    nwait = 0; rd = '0; er = 1'b1;
    for (guard = 0; guard < 40; guard++) begin
      @(negedge clk);
      if ((ws ? ws_pready : pready) === 1'b1) break;
      nwait++;
      @(posedge clk); #1;
    end
    if (guard == 40) begin
      checks++; errors++;
      $display("FAIL apb_timeout: addr %h got no pready, expected pready within 40 cycles", addr);
    end else begin
      rd = ws ? ws_prdata : prdata;
      er = ws ? ws_pslverr : pslverr;
    end
    @(posedge clk); #1;
    psel = 1'b0; psel_ws = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, output logic e);
    logic [31:0] r; int n;
    apb(1'b0, 1'b1, a, d, r, e, n);
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] r, output logic e);
    int n;
    apb(1'b0, 1'b0, a, 32'h0, r, e, n);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #20;
    checks++; if (pready !== 1'b0 || pslverr !== 1'b0) begin errors++; $display("FAIL reset_pready: got %b/%b expected 0/0", pready, pslverr); end
    checks++; if (prdata !== 32'h0) begin errors++; $display("FAIL reset_prdata: got %h expected 0", prdata); end
    checks++; if (req !== 1'b0 || mc_en !== 1'b0) begin errors++; $display("FAIL reset_req_en: got %b/%b expected 0/0", req, mc_en); end
    checks++; if (t_rtp !== 8'h0 || rf0 !== 25'h0 || ws_pready !== 1'b0) begin errors++; $display("FAIL reset_active: got %h/%h/%b expected 0", t_rtp, rf0, ws_pready); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_stage_readback;
    logic e; logic [31:0] r;
    wr(8'h0C, 32'hA5C3_1E77, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL t1_wr_err: got %b expected 0", e); end
    rd(8'h0C, r, e);
    checks++; if (r !== 32'hA5C31E77 || e !== 1'b0) begin errors++; $display("FAIL t1_readback: got %h/%b expected a5c31e77/0", r, e); end
    checks++; if (t_rtp !== 8'h00) begin errors++; $display("FAIL t1_trtp_unshadowed: got %h expected 00", t_rtp); end
  endtask

  task automatic test_commit_handshake;
    logic e; logic [31:0] r; int hi;
    wr(8'h00, 32'h1, e);
    wr(8'h1C, 32'h1, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL t2_cmd_err: got %b expected 0", e); end
    hi = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); if (req === 1'b1) hi++;
    end
    @(posedge clk); #1 ack = 1'b1;
    @(negedge clk); if (req === 1'b1) hi++;
    @(posedge clk); #1 ack = 1'b0;
    checks++; if (hi !== 6) begin errors++; $display("FAIL t2_req_cycles: got %0d expected 6", hi); end
    @(negedge clk);
    checks++; if (req !== 1'b0) begin errors++; $display("FAIL t2_req_drop: got %b expected 0", req); end
    checks++; if ({t_rtp, t_wr, t_rcd_rd, t_rcd_wr} !== 32'hA5C31E77) begin errors++; $display("FAIL t2_active: got %h expected a5c31e77", {t_rtp, t_wr, t_rcd_rd, t_rcd_wr}); end
    rd(8'h20, r, e);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL t2_status: got %h expected 0", r); end
  endtask

  task automatic test_pending_block;
    logic e; logic [31:0] r;
    wr(8'h10, 32'h0123456, e);
    wr(8'h1C, 32'h1, e);
    rd(8'h20, r, e);
    checks++; if (r !== 32'h1) begin errors++; $display("FAIL t3_status_pending: got %h expected 1", r); end
    mc_busy = 1'b1;
    rd(8'h20, r, e);
    checks++; if (r !== 32'h3) begin errors++; $display("FAIL t3_status_busy: got %h expected 3", r); end
    mc_busy = 1'b0;
    wr(8'h10, 32'h1FF_FFFF, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL t3_blocked_err: got %b expected 1", e); end
    rd(8'h10, r, e);
    checks++; if (r !== 32'h0123456) begin errors++; $display("FAIL t3_blocked_keep: got %h expected 00123456", r); end
    wr(8'h1C, 32'h1, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL t3_cmd_blocked: got %b expected 1", e); end
    wr(8'h00, 32'h1, e);
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL t3_mc_en_ok: got %b expected 0", e); end
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    checks++; if (req !== 1'b0 || rf0 !== 25'h0123456) begin errors++; $display("FAIL t3_commit: got %b/%h expected 0/0123456", req, rf0); end
    // dropping mc_en finishes a pending commit without an ack
    wr(8'h04, 32'h2, e);
    wr(8'h1C, 32'h1, e);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL t3_req_up: got %b expected 1", req); end
    wr(8'h00, 32'h0, e);
    @(posedge clk); #1;
    checks++; if (req !== 1'b0 || prio !== 2'd2) begin errors++; $display("FAIL t3_en_drop: got %b/%0d expected 0/2", req, prio); end
    wr(8'h04, 32'h1, e);
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    checks++; if (req !== 1'b0 || prio !== 2'd2) begin errors++; $display("FAIL t3_stray_ack: got %b/%0d expected 0/2", req, prio); end
  endtask

  task automatic test_wait_states;
    logic e; logic [31:0] r; int n;
    apb(1'b1, 1'b0, 8'h04, 32'h0, r, e, n);
    checks++; if (n !== 3 || r !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL t4_ws_read: got %0d/%h/%b expected 3/0/0", n, r, e); end
    apb(1'b1, 1'b1, 8'h04, 32'h3, r, e, n);
    apb(1'b1, 1'b0, 8'h04, 32'h0, r, e, n);
    checks++; if (n !== 3 || r !== 32'h3) begin errors++; $display("FAIL t4_ws_readback: got %0d/%h expected 3/3", n, r); end
    apb(1'b0, 1'b0, 8'h04, 32'h0, r, e, n);
    checks++; if (n !== 0 || r !== 32'h1) begin errors++; $display("FAIL t4_zero_wait: got %0d/%h expected 0/1", n, r); end
    rd(8'h24, r, e);
    checks++; if (e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL t4_addr_24: got %b/%h expected 1/0", e, r); end
    rd(8'hFC, r, e);
    checks++; if (e !== 1'b1 || r !== 32'h0) begin errors++; $display("FAIL t4_addr_fc: got %b/%h expected 1/0", e, r); end
    wr(8'h20, 32'h7, e);
    checks++; if (e !== 1'b1) begin errors++; $display("FAIL t4_status_wr: got %b expected 1", e); end
    wr(8'h1C, 32'h0, e);
    rd(8'h1C, r, e);
    checks++; if (r !== 32'h0 || e !== 1'b0) begin errors++; $display("FAIL t4_cmd_read: got %h/%b expected 0/0", r, e); end
  endtask

  task automatic test_idle_commit;
    logic e; logic [31:0] r;
    wr(8'h08, 32'h00FF_FFFF, e);
    wr(8'h1C, 32'h1, e);
    checks++; if (e !== 1'b0 || req !== 1'b0) begin errors++; $display("FAIL t5_no_req: got %b/%b expected 0/0", e, req); end
    checks++; if ({t_rc, t_rp, t_ras} !== 24'hFFFFFF) begin errors++; $display("FAIL t5_active: got %h expected ffffff", {t_rc, t_rp, t_ras}); end
    wr(8'h1C, 32'h2, e);
    rd(8'h20, r, e);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL t5_lock_ignored: got %h expected 0", r); end
    rd(8'h08, r, e);
    checks++; if (r !== 32'h00FFFFFF) begin errors++; $display("FAIL t5_readback: got %h expected 00ffffff", r); end
  endtask

  task automatic test_async_reset;
    logic e; logic [31:0] r;
    wr(8'h00, 32'h1, e);
    wr(8'h1C, 32'h1, e);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL t6_req_before: got %b expected 1", req); end
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    checks++; if (req !== 1'b0 || mc_en !== 1'b0) begin errors++; $display("FAIL t6_async_req: got %b/%b expected 0/0", req, mc_en); end
    checks++; if (t_ras !== 8'h0 || t_rtp !== 8'h0 || rf0 !== 25'h0) begin errors++; $display("FAIL t6_async_active: got %h/%h/%h expected 0", t_ras, t_rtp, rf0); end
    @(negedge clk); rst_n = 1'b1;
    rd(8'h08, r, e);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL t6_staging_cleared: got %h expected 0", r); end
    rd(8'h20, r, e);
    checks++; if (r !== 32'h0) begin errors++; $display("FAIL t6_status_cleared: got %h expected 0", r); end
    wr(8'h00, 32'h1, e);
    wr(8'h0C, 32'h0102_0304, e);
    wr(8'h1C, 32'h1, e);
    checks++; if (req !== 1'b1) begin errors++; $display("FAIL t6_req_again: got %b expected 1", req); end
    @(posedge clk); #1 ack = 1'b1;
    @(posedge clk); #1 ack = 1'b0;
    checks++; if (req !== 1'b0 || {t_rtp, t_wr, t_rcd_rd, t_rcd_wr} !== 32'h01020304) begin errors++; $display("FAIL t6_recommit: got %b/%h expected 0/01020304", req, {t_rtp, t_wr, t_rcd_rd, t_rcd_wr}); end
  endtask

  initial begin
    test_reset;
    test_stage_readback;
    test_commit_handshake;
    test_pending_block;
    test_wait_states;
    test_idle_commit;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
